qpu_ifu_itcm_rsp: RTL and testbench
===================================

// Module: qpu_ifu_itcm_rsp
// PURPOSE
//  Fetch-side responder for the IFU fetch protocol: accepts ifu_req (valid/ready, pc, seq)
//  and returns one ifu_rsp instruction per request, in order, from a 1-cycle sync-read ITCM.
//  Sits between QPU_ifu_ifetch and the instruction SRAM.
//  Adds a host program-load write port and a 2-entry response skid.
//  ifu_req_ready never depends combinationally on ifu_rsp_ready (no IFU/ITCM comb loop).
// PARAMETERS
//  PC_W     32      fetch PC width
//  INSTR_W  32      instruction width
//  AW       10      ITCM word-address bits (2^AW words)
//  BASE     32'h0   ITCM byte base address
//  ERR_INSTR 32'h0  instruction returned for out-of-range PC
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  ifu_req_valid  in   1        fetch request valid
//  ifu_req_ready  out  1        fetch request ready
//  ifu_req_pc     in   PC_W     fetch byte address; pc[1:0] ignored
//  ifu_req_seq    in   1        sequential hint; no functional effect
//  ifu_rsp_valid  out  1        response valid
//  ifu_rsp_ready  in   1        response ready
//  ifu_rsp_instr  out  INSTR_W  fetched instruction
//  host_wr_valid  in   1        program-load write valid
//  host_wr_ready  out  1        program-load write ready
//  host_wr_addr   in   AW       ITCM word address
//  host_wr_data   in   INSTR_W  write data
//  ram_cs         out  1        SRAM select (comb, one per accepted access)
//  ram_we         out  1        SRAM write enable
//  ram_addr       out  AW       SRAM word address
//  ram_wdata      out  INSTR_W  SRAM write data
//  ram_dout       in   INSTR_W  SRAM read data, valid cycle after read cs
//  itcm_idle      out  1        no response in flight or buffered
// BEHAVIOUR
//  - Reset: occ=0; stage_v=0; skid_v=0; ifu_rsp_valid=0; ifu_req_ready=1;
//    host_wr_ready=1; ram_cs=0; itcm_idle=1.
//  - occ (0..2, registered): responses issued but not yet handshaked.
//  - ifu_req_ready = ~host_wr_valid & (occ!=2).
//    Host writes take priority over fetches.
//  - host_wr_ready = (occ==0). Write: ram_cs=1, ram_we=1, no response.
//  - Req handshake, in-range (BASE <= pc < BASE+4*2^AW): ram_cs=1, ram_we=0,
//    ram_addr=(pc-BASE)[AW+1:2]. Next cycle stage_v=1, data taken from ram_dout.
//  - Out-of-range: no SRAM access. Stage loads ERR_INSTR next cycle (oor flag).
//    Latency is identical to in-range.
//  - Output mux: skid_v ? skid : stage. ifu_rsp_valid = skid_v | stage_v.
//  - Stage data not consumed while a new read issues: stage data moves into skid
//    on that edge. The new read then refills the stage.
//  - Stage data not consumed, no new read: held on the SRAM output with no
//    re-read. ram_cs=0 guarantees dout is stable.
//  - Order: skid drains before stage. Strict FIFO; never more than 2 entries.
//  - Simultaneous rsp handshake + req handshake: occ unchanged. Back-to-back
//    throughput is 1 fetch/cycle.
//  - occ_nxt = occ + req_hsk - rsp_hsk. All 2-bit arithmetic; never wraps.
//  - itcm_idle = (occ==0).
//  - Async reset mid-operation discards all in-flight/buffered responses.
//    Outputs go to reset values immediately.
// TESTING
//  1. Load 0xA0..0xA3 via host to words 0..3. Fetch pc 0,4,8,C back-to-back, rsp_ready=1.
//     -> rsp A0..A3 on consecutive cycles, 1-cycle latency.
//  2. Fetch pc 0,4 with rsp_ready=0.
//     -> occ=2, req_ready=0, rsp_instr=A0 held. Raise ready -> A0 then A1.
//  3. pc=BASE+4*2^AW -> no ram_cs; rsp ERR_INSTR after 1 cycle.
//  4. host_wr_valid held with occ=1 -> host_wr_ready=0, req_ready=0.
//     After rsp drains, write occurs; next fetch returns new data.
//  5. Assert rst_n=0 while occ=2 -> rsp_valid=0, occ=0 immediately; no stale response after release.
//  6. Random rsp_ready/req_valid 10k cycles vs scoreboard -> in-order, no loss or duplication.

Source files
------------

// File: rtl/qpu_ifu_itcm_rsp.sv
// ITCM fetch responder: in-order instruction responses from a 1-cycle sync-read SRAM,
// with a host program-load port and a 2-entry response skid (stage + skid).
module qpu_ifu_itcm_rsp #(
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter int unsigned         AW        = 10,
    parameter logic [PC_W-1:0]     BASE      = '0,
    parameter logic [INSTR_W-1:0]  ERR_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [PC_W-1:0]    ifu_req_pc,
    input  logic               ifu_req_seq,
    output logic               ifu_rsp_valid,
    input  logic               ifu_rsp_ready,
    output logic [INSTR_W-1:0] ifu_rsp_instr,
    input  logic               host_wr_valid,
    output logic               host_wr_ready,
    input  logic [AW-1:0]      host_wr_addr,
    input  logic [INSTR_W-1:0] host_wr_data,
    output logic               ram_cs,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [INSTR_W-1:0] ram_wdata,
    input  logic [INSTR_W-1:0] ram_dout,
    output logic               itcm_idle
);

    localparam int unsigned OCC_W = 2;

    logic [OCC_W-1:0]   occ;
    logic               stage_v;
    logic               stage_oor;
    logic               skid_v;
    logic [INSTR_W-1:0] skid_data;

    logic               req_hsk;
    logic               rsp_hsk;
    logic               wr_hsk;
    logic               in_range;
    logic               stage_pop;
    logic               skid_pop;
    logic               stage_to_skid;
    logic [PC_W-1:0]    pc_off;
    logic [INSTR_W-1:0] stage_data;
    logic               unused_c;

    // Byte offset into the ITCM; in range when no bits above the word index are set.
    assign pc_off   = ifu_req_pc - BASE;
    assign in_range = (ifu_req_pc >= BASE) && (pc_off[PC_W-1:AW+2] == '0);
    assign unused_c = ^{ifu_req_seq, pc_off[1:0]};

    // Ready depends only on registered occupancy and the host request, never on rsp_ready.
    assign ifu_req_ready = ~host_wr_valid & (occ != OCC_W'(2));
    assign host_wr_ready = (occ == '0);
    assign itcm_idle     = (occ == '0);

    assign wr_hsk  = host_wr_valid & host_wr_ready;
    assign req_hsk = ifu_req_valid & ifu_req_ready;
    assign rsp_hsk = ifu_rsp_valid & ifu_rsp_ready;

    assign ram_cs    = wr_hsk | (req_hsk & in_range);
    assign ram_we    = wr_hsk;
    assign ram_addr  = wr_hsk ? host_wr_addr : pc_off[AW+1:2];
    assign ram_wdata = host_wr_data;

    // Stage data lives on the SRAM output; it stays stable because no read issues while held.
    assign stage_data    = stage_oor ? ERR_INSTR : ram_dout;
    assign ifu_rsp_valid = skid_v | stage_v;
    assign ifu_rsp_instr = skid_v ? skid_data : stage_data;

    assign skid_pop      = rsp_hsk & skid_v;
    assign stage_pop     = rsp_hsk & ~skid_v;
    assign stage_to_skid = stage_v & ~stage_pop & req_hsk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            stage_v   <= 1'b0;
            stage_oor <= 1'b0;
            skid_v    <= 1'b0;
            skid_data <= '0;
        end else begin
            occ <= occ + OCC_W'(req_hsk) - OCC_W'(rsp_hsk);

            if (req_hsk) begin
                stage_v   <= 1'b1;
                stage_oor <= ~in_range;
            end else if (stage_pop) begin
                stage_v <= 1'b0;
            end

            // An unconsumed stage entry is parked in the skid before the new read overwrites dout.
            if (stage_to_skid) begin
                skid_v    <= 1'b1;
                skid_data <= stage_data;
            end else if (skid_pop) begin
                skid_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qpu_ifu_itcm_rsp.sv
// Scoreboard bench for qpu_ifu_itcm_rsp: SRAM model, shadow-memory reference, directed + random traffic.
module tb_qpu_ifu_itcm_rsp;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned AW      = 10;
    localparam int unsigned WORDS   = 1 << AW;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ifu_req_valid = 1'b0;
    logic               ifu_req_ready;
    logic [PC_W-1:0]    ifu_req_pc = '0;
    logic               ifu_req_seq = 1'b0;
    logic               ifu_rsp_valid;
    logic               ifu_rsp_ready = 1'b1;
    logic [INSTR_W-1:0] ifu_rsp_instr;
    logic               host_wr_valid = 1'b0;
    logic               host_wr_ready;
    logic [AW-1:0]      host_wr_addr = '0;
    logic [INSTR_W-1:0] host_wr_data = '0;
    logic               ram_cs;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [INSTR_W-1:0] ram_wdata;
    logic [INSTR_W-1:0] ram_dout = '0;
    logic               itcm_idle;

    int n_cmp = 0;
    int n_err = 0;
    logic [INSTR_W-1:0] sram   [WORDS];
    logic [INSTR_W-1:0] shadow [WORDS];
    logic [INSTR_W-1:0] exp_q [$];

    qpu_ifu_itcm_rsp #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .AW(AW), .BASE(BASE), .ERR_INSTR(ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_dout(ram_dout), .itcm_idle(itcm_idle)
    );

    always #5 clk = ~clk;

    // Single-port sync SRAM: dout only changes on a read select.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) sram[ram_addr] <= ram_wdata;
            else        ram_dout <= sram[ram_addr];
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic pc_in_range(input logic [31:0] pc);
        longint unsigned p = longint'(pc);
        longint unsigned b = longint'(BASE);
        return (p >= b) && (p < b + 4 * longint'(WORDS));
    endfunction

    // Monitor: the queue length is the number of accepted-but-unanswered fetches.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
            chk("rst_idle", 32'(itcm_idle), 32'd1);
        end else begin
            int n;
            logic [31:0] pc;
            n = exp_q.size();
            chk("rsp_valid", 32'(ifu_rsp_valid), 32'(n != 0));
            chk("idle", 32'(itcm_idle), 32'(n == 0));
            chk("req_ready", 32'(ifu_req_ready), 32'(!host_wr_valid && n < 2));
            chk("wr_ready", 32'(host_wr_ready), 32'(n == 0));
            if (ifu_rsp_valid && ifu_rsp_ready && n != 0)
                chk("rsp_instr", ifu_rsp_instr, exp_q.pop_front());
            if (host_wr_valid && host_wr_ready) begin
                shadow[host_wr_addr] = host_wr_data;
                chk("wr_cs", 32'({ram_cs, ram_we}), 32'b11);
                chk("wr_addr", 32'(ram_addr), 32'(host_wr_addr));
                chk("wr_data", ram_wdata, host_wr_data);
            end else if (ifu_req_valid && ifu_req_ready) begin
                pc = ifu_req_pc;
                if (pc_in_range(pc)) begin
                    exp_q.push_back(shadow[(pc - BASE) / 4]);
                    chk("rd_cs", 32'({ram_cs, ram_we}), 32'b10);
                    chk("rd_addr", 32'(ram_addr), (pc - BASE) / 4);
                end else begin
                    exp_q.push_back(ERR);
                    chk("oor_no_cs", 32'(ram_cs), 32'd0);
                end
            end else begin
                chk("idle_cs", 32'(ram_cs), 32'd0);
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
        bit got = 0;
        host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (host_wr_ready) begin got = 1; break; end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL host_write_timeout: addr %h never accepted", a);
        end
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bit got = 0;
        ifu_req_valid = 1'b1; ifu_req_pc = pc; ifu_req_seq = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin got = 1; break; end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_timeout: pc %h never accepted", pc);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            sram[i] = '0;
            shadow[i] = '0;
        end
        #2;
        chk("reset_req_ready", 32'(ifu_req_ready), 32'd1);
        chk("reset_wr_ready", 32'(host_wr_ready), 32'd1);
        chk("reset_ram_cs", 32'(ram_cs), 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        // Program load then back-to-back fetches.
        for (int i = 0; i < 4; i++) host_write(AW'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) fetch(BASE + 32'(4 * i));
        cycles(3);

        // Responses held with rsp_ready low; skid fills to two entries.
        ifu_rsp_ready = 1'b0;
        fetch(BASE);
        fetch(BASE + 4);
        @(negedge clk);
        chk("held_instr", ifu_rsp_instr, 32'hA0);
        chk("full_req_ready", 32'(ifu_req_ready), 32'd0);
        cycles(2);
        ifu_rsp_ready = 1'b1;
        cycles(3);

        // Out of range above and below the window.
        fetch(BASE + 32'(4 * WORDS));
        fetch(BASE - 4);
        fetch(BASE + 32'(4 * WORDS) - 4);
        cycles(3);

        // Host write blocked while a response is outstanding.
        ifu_rsp_ready = 1'b0;
        fetch(BASE);
        fork
            host_write(AW'(0), 32'hB0);
            begin
                repeat (2) @(negedge clk);
                chk("wr_blocked", 32'(host_wr_ready), 32'd0);
                chk("req_blocked", 32'(ifu_req_ready), 32'd0);
                @(posedge clk); #1;
                ifu_rsp_ready = 1'b1;
            end
        join
        fetch(BASE);
        @(negedge clk);
        chk("refetch_new", ifu_rsp_instr, 32'hB0);
        cycles(3);

        // Async reset with two responses buffered.
        ifu_rsp_ready = 1'b0;
        fetch(BASE + 8);
        fetch(BASE + 12);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        chk("async_idle", 32'(itcm_idle), 32'd1);
        cycles(2);
        rst_n = 1'b1;
        ifu_rsp_ready = 1'b1;
        cycles(4);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            host_wr_valid = ($urandom_range(0, 15) == 0);
            host_wr_addr  = AW'($urandom_range(0, 15));
            host_wr_data  = $urandom;
            ifu_req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       ifu_req_pc = BASE + 32'(4 * WORDS) + $urandom_range(0, 64);
                1:       ifu_req_pc = BASE - 32'($urandom_range(1, 64));
                default: ifu_req_pc = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            cycles(1);
        end
        ifu_req_valid = 1'b0;
        host_wr_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        cycles(5);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
